logs_seq: RTL

LOGS_SEQ -- requirements
Module: logs_seq

---
 rtl/logs_pkg.sv | 14 +
 rtl/logs_prescaler.sv | 25 ++
 rtl/logs_seq.sv | 105 ++++++++++
 3 files changed

// File: rtl/logs_pkg.sv
// rtl/logs_pkg.sv - shared state encodings for the pattern sequencer
package logs_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NOTE = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_NOTE = NOTE,
        ST_GAP  = GAP
    } state_t;

endpackage

// File: rtl/logs_prescaler.sv
// rtl/logs_prescaler.sv - free-running divider emitting a one-clk step pulse every PRE clks
module logs_prescaler #(
    parameter int PRE = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic step
);

    localparam int CW = (PRE > 1) ? $clog2(PRE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign step = (cnt == LAST);

endmodule

// File: rtl/logs_seq.sv
// rtl/logs_seq.sv - note pattern sequencer driving an NCO frequency word and gate
module logs_seq
    import logs_pkg::*;
#(
    parameter int N     = 5,
    parameter int LEN   = 8,
    parameter int PRE   = 4,
    parameter int DUR_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop,
    input  logic [DUR_W-1:0]        tempo,
    input  logic                    wr_en,
    input  logic [$clog2(LEN)-1:0]  wr_addr,
    input  logic [N-2:0]            wr_data,
    output logic                    step,
    output logic [N-2:0]            freq_out,
    output logic                    gate,
    output logic                    busy,
    output logic [$clog2(LEN)-1:0]  pos
);

    localparam int AW = $clog2(LEN);
    localparam logic [AW-1:0] LAST_POS = AW'(LEN - 1);

    state_t             state;
    logic [DUR_W-1:0]   dur;
    logic [N-2:0]       mem [LEN];
    logic [AW-1:0]      pos_next;

    logs_prescaler #(.PRE(PRE)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (step)
    );

    assign pos_next = pos + 1'b1;

    // Writes land at the edge, so a same-clk latch below still sees the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LEN; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pos      <= '0;
            dur      <= '0;
            freq_out <= '0;
        end else if (stop) begin
            state    <= ST_IDLE;
            freq_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_NOTE;
                        pos      <= '0;
                        freq_out <= mem[0];
                        dur      <= tempo;
                    end
                end
                ST_NOTE: begin
                    if (step) begin
                        if (dur == '0) begin
                            state    <= ST_GAP;
                            freq_out <= '0;
                        end else begin
                            dur <= dur - 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (step) begin
                        if (pos == LAST_POS && !loop) begin
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_NOTE;
                            pos      <= pos_next;
                            freq_out <= mem[pos_next];
                            dur      <= tempo;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    freq_out <= '0;
                end
            endcase
        end
    end

    assign gate = (state == ST_NOTE) && (freq_out != '0);
    assign busy = (state != ST_IDLE);

endmodule
